// File: rtl/cpu_ifetch_pkg.sv
// Shared fetch definitions: reset vector, queue depth, memory FSM states and the
// long-form opcode classifier that cpu_decode also relies on.
package cpu_ifetch_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_1000;
  localparam int          QDEPTH_DEFAULT       = 8;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_FLUSH
  } memState_e;

  // Long forms carry a 32-bit immediate in the two halfwords after the opcode.
  function automatic logic isLongOp(input logic [7:0] opc8);
    case (opc8)
      8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
      8'h1F, 8'h20, 8'h22, 8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39:
        isLongOp = 1'b1;
      default:
        isLongOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ifetch_if.sv
// Instruction memory read bus: single outstanding request, stb held until ack.
interface cpu_ifetch_if;

  logic [31:0] address;
  logic        stb;
  logic        ack;
  logic [31:0] data;

  modport master (output address, output stb, input ack, input data);
  modport slave  (input address, input stb, output ack, output data);

endinterface

// File: rtl/cpu_ifetch_queue.sv
// Halfword FIFO between the memory side and the instruction aligner:
// up to two writes and up to three reads per cycle, with a separate fill count.
module cpu_ifetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_clear,
  input  logic [1:0]                 i_wrCount,
  input  logic [15:0]                i_wrHw0,
  input  logic [15:0]                i_wrHw1,
  input  logic [1:0]                 i_popCount,
  output logic [15:0]                o_hw0,
  output logic [15:0]                o_hw1,
  output logic [15:0]                o_hw2,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_rd1;
  logic [AW-1:0] w_rd2;
  logic [AW-1:0] w_wr1;

  assign w_rd1 = r_rdPtr + AW'(1);
  assign w_rd2 = r_rdPtr + AW'(2);
  assign w_wr1 = r_wrPtr + AW'(1);

  assign o_hw0   = r_mem[r_rdPtr];
  assign o_hw1   = r_mem[w_rd1];
  assign o_hw2   = r_mem[w_rd2];
  assign o_count = r_count;

  // Pointers wrap naturally at DEPTH; the caller guarantees no overflow or underflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || i_clear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_wrCount != 2'd0) r_mem[r_wrPtr] <= i_wrHw0;
      if (i_wrCount == 2'd2) r_mem[w_wr1]   <= i_wrHw1;
      r_wrPtr <= r_wrPtr + AW'(i_wrCount);
      r_rdPtr <= r_rdPtr + AW'(i_popCount);
      r_count <= r_count + CW'(i_wrCount) - CW'(i_popCount);
    end
  end

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch/align: word fetch FSM with branch flush, halfword queue,
// and a registered one-instruction output stage for cpu_decode.
module cpu_ifetch
  import cpu_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          QDEPTH       = QDEPTH_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                branch_flag_i,
  input  logic [31:0]         branch_target_i,
  cpu_ifetch_if.master        imem,
  output logic [15:0]         opcode_o,
  output logic [31:0]         operand_o,
  output logic                valid_o,
  output logic [31:0]         pc_o
);

  localparam int CW = $clog2(QDEPTH + 1);

  memState_e     r_state;
  logic          r_stb;
  logic [31:0]   r_addr;
  logic [31:0]   r_ptr;
  logic          r_skip;
  logic [31:0]   r_headPc;
  logic [15:0]   r_opcode;
  logic [31:0]   r_operand;
  logic          r_valid;
  logic [31:0]   r_pc;

  logic [15:0]   w_hw0, w_hw1, w_hw2;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_nextCount;
  logic          w_long, w_complete, w_advance, w_ackWrite;
  logic [1:0]    w_wrCount, w_popCount;
  logic [31:0]   w_targetWord, w_targetHw;

  assign w_targetWord = branch_target_i & ~32'd3;
  assign w_targetHw   = branch_target_i & ~32'd1;

  assign w_long     = isLongOp(w_hw0[15:8]);
  assign w_complete = (w_count >= CW'(1)) && (!w_long || (w_count >= CW'(3)));
  assign w_advance  = !r_valid || !stall_i;
  assign w_popCount = (!branch_flag_i && w_advance && w_complete) ? (w_long ? 2'd3 : 2'd1) : 2'd0;

  // The first word after a redirect to an odd halfword contributes only its lower half.
  assign w_ackWrite  = (r_state == MEM_REQ) && imem.ack && !branch_flag_i;
  assign w_wrCount   = w_ackWrite ? (r_skip ? 2'd1 : 2'd2) : 2'd0;
  assign w_nextCount = w_count + CW'(w_wrCount) - CW'(w_popCount);

  cpu_ifetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clear    (branch_flag_i),
    .i_wrCount  (w_wrCount),
    .i_wrHw0    (r_skip ? imem.data[15:0] : imem.data[31:16]),
    .i_wrHw1    (imem.data[15:0]),
    .i_popCount (w_popCount),
    .o_hw0      (w_hw0),
    .o_hw1      (w_hw1),
    .o_hw2      (w_hw2),
    .o_count    (w_count)
  );

  // Memory FSM: FLUSH keeps the stale request on the bus until its ack is swallowed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= MEM_IDLE;
      r_stb   <= 1'b0;
      r_addr  <= RESET_VECTOR & ~32'd3;
      r_ptr   <= RESET_VECTOR & ~32'd3;
      r_skip  <= 1'b0;
    end else if (branch_flag_i) begin
      r_ptr  <= w_targetWord;
      r_skip <= branch_target_i[1];
      if (r_state != MEM_IDLE && !imem.ack) begin
        r_state <= MEM_FLUSH;
      end else begin
        r_state <= MEM_REQ;
        r_stb   <= 1'b1;
        r_addr  <= w_targetWord;
      end
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_count <= CW'(QDEPTH - 2)) begin
            r_state <= MEM_REQ;
            r_stb   <= 1'b1;
            r_addr  <= r_ptr;
          end
        end
        MEM_REQ: begin
          if (imem.ack) begin
            r_ptr  <= r_ptr + 32'd4;
            r_skip <= 1'b0;
            if (w_nextCount <= CW'(QDEPTH - 2)) begin
              r_addr <= r_ptr + 32'd4;
            end else begin
              r_state <= MEM_IDLE;
              r_stb   <= 1'b0;
            end
          end
        end
        MEM_FLUSH: begin
          if (imem.ack) begin
            r_state <= MEM_REQ;
            r_addr  <= r_ptr;
          end
        end
        default: begin
          r_state <= MEM_IDLE;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_opcode  <= 16'h0000;
      r_operand <= 32'h0000_0000;
      r_pc      <= 32'h0000_0000;
      r_headPc  <= RESET_VECTOR;
    end else if (branch_flag_i) begin
      r_valid  <= 1'b0;
      r_headPc <= w_targetHw;
    end else if (w_advance) begin
      if (w_complete) begin
        r_valid   <= 1'b1;
        r_opcode  <= w_hw0;
        r_operand <= w_long ? {w_hw1, w_hw2} : 32'h0000_0000;
        r_pc      <= r_headPc;
        r_headPc  <= r_headPc + (w_long ? 32'd6 : 32'd2);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign imem.address = r_addr;
  assign imem.stb     = r_stb;
  assign opcode_o     = r_opcode;
  assign operand_o    = r_operand;
  assign valid_o      = r_valid;
  assign pc_o         = r_pc;

endmodule
